// File: rtl/ex_stage_alu.sv
// MIPS execute stage: operand forwarding, ALU, and the EX/MEM pipeline register.
// Results appear one clock after the inputs are presented; the register can stall or take a bubble.
module ex_stage_alu #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inValid,
  input  logic                  inStall,
  input  logic                  inFlush,
  input  logic [3:0]            inALUControl,
  input  logic                  inALUSrc,
  input  logic [DATA_W-1:0]     inReadData1,
  input  logic [DATA_W-1:0]     inReadData2,
  input  logic [DATA_W-1:0]     inImmediate,
  input  logic [1:0]            inForwardA,
  input  logic [1:0]            inForwardB,
  input  logic [DATA_W-1:0]     inFwdMemData,
  input  logic [DATA_W-1:0]     inFwdWbData,
  input  logic [REG_ADDR_W-1:0] inWriteReg,
  input  logic                  inRegWrite,
  input  logic                  inMemToReg,
  input  logic                  inMemRead,
  input  logic                  inMemWrite,
  output logic                  outValid,
  output logic [DATA_W-1:0]     outALUResult,
  output logic                  outZero,
  output logic                  outOverflow,
  output logic [DATA_W-1:0]     outStoreData,
  output logic [REG_ADDR_W-1:0] outWriteReg,
  output logic                  outRegWrite,
  output logic                  outMemToReg,
  output logic                  outMemRead,
  output logic                  outMemWrite
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_XOR = 4'b1001
  } alu_op_e;

  localparam int unsigned MSB = DATA_W - 1;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] b_fwd;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] result;
  logic              overflow;
  logic              add_ovf;
  logic              sub_ovf;

  always_comb begin
    op_a = inReadData1;
    unique case (inForwardA)
      2'b01:   op_a = inFwdWbData;
      2'b10:   op_a = inFwdMemData;
      default: op_a = inReadData1;
    endcase
  end

  always_comb begin
    b_fwd = inReadData2;
    unique case (inForwardB)
      2'b01:   b_fwd = inFwdWbData;
      2'b10:   b_fwd = inFwdMemData;
      default: b_fwd = inReadData2;
    endcase
  end

  assign op_b = inALUSrc ? inImmediate : b_fwd;
  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  // Signed overflow: like-signed operands (B effectively inverted for SUB) produce a result of the other sign.
  assign add_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB]  != op_a[MSB]);
  assign sub_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);

  always_comb begin
    result   = sum;
    overflow = 1'b0;
    case (alu_op_e'(inALUControl))
      OP_AND: result = op_a & op_b;
      OP_OR:  result = op_a | op_b;
      OP_XOR: result = op_a ^ op_b;
      OP_SLT: begin
        result    = '0;
        result[0] = ($signed(op_a) < $signed(op_b));
      end
      OP_SUB: begin
        result   = diff;
        overflow = sub_ovf;
      end
      default: begin
        // OP_ADD and every undefined code share the adder, matching the decoder default.
        result   = sum;
        overflow = add_ovf;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || inFlush || (!inStall && !inValid)) begin
      outValid     <= 1'b0;
      outALUResult <= '0;
      outZero      <= 1'b0;
      outOverflow  <= 1'b0;
      outStoreData <= '0;
      outWriteReg  <= '0;
      outRegWrite  <= 1'b0;
      outMemToReg  <= 1'b0;
      outMemRead   <= 1'b0;
      outMemWrite  <= 1'b0;
    end else if (!inStall) begin
      outValid     <= 1'b1;
      outALUResult <= result;
      outZero      <= (result == '0);
      outOverflow  <= overflow;
      outStoreData <= b_fwd;
      outWriteReg  <= inWriteReg;
      outRegWrite  <= inRegWrite;
      outMemToReg  <= inMemToReg;
      outMemRead   <= inMemRead;
      outMemWrite  <= inMemWrite;
    end
  end

endmodule

// File: tb/tb_ex_stage_alu.sv
// Self-checking bench for ex_stage_alu: expected EX/MEM contents are queued when stimulus
// is driven and compared against the registered outputs one clock later.
module tb_ex_stage_alu;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inStall;
  logic        inFlush;
  logic [3:0]  inALUControl;
  logic        inALUSrc;
  logic [31:0] inReadData1;
  logic [31:0] inReadData2;
  logic [31:0] inImmediate;
  logic [1:0]  inForwardA;
  logic [1:0]  inForwardB;
  logic [31:0] inFwdMemData;
  logic [31:0] inFwdWbData;
  logic [4:0]  inWriteReg;
  logic        inRegWrite;
  logic        inMemToReg;
  logic        inMemRead;
  logic        inMemWrite;
  logic        outValid;
  logic [31:0] outALUResult;
  logic        outZero;
  logic        outOverflow;
  logic [31:0] outStoreData;
  logic [4:0]  outWriteReg;
  logic        outRegWrite;
  logic        outMemToReg;
  logic        outMemRead;
  logic        outMemWrite;

  typedef struct packed {
    logic        valid;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic [31:0] store;
    logic [4:0]  wreg;
    logic        rw;
    logic        m2r;
    logic        mr;
    logic        mw;
  } out_t;

  out_t scoreboard[$];
  out_t got;
  out_t exp;
  out_t last_exp;
  int   checks;
  int   failures;

  ex_stage_alu #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inStall(inStall), .inFlush(inFlush),
    .inALUControl(inALUControl), .inALUSrc(inALUSrc),
    .inReadData1(inReadData1), .inReadData2(inReadData2), .inImmediate(inImmediate),
    .inForwardA(inForwardA), .inForwardB(inForwardB),
    .inFwdMemData(inFwdMemData), .inFwdWbData(inFwdWbData),
    .inWriteReg(inWriteReg), .inRegWrite(inRegWrite), .inMemToReg(inMemToReg),
    .inMemRead(inMemRead), .inMemWrite(inMemWrite),
    .outValid(outValid), .outALUResult(outALUResult), .outZero(outZero),
    .outOverflow(outOverflow), .outStoreData(outStoreData), .outWriteReg(outWriteReg),
    .outRegWrite(outRegWrite), .outMemToReg(outMemToReg), .outMemRead(outMemRead),
    .outMemWrite(outMemWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t sample_outputs();
    out_t o;
    o = '{outValid, outALUResult, outZero, outOverflow, outStoreData, outWriteReg,
          outRegWrite, outMemToReg, outMemRead, outMemWrite};
    return o;
  endfunction

  function automatic out_t mk(logic valid, logic [31:0] res, logic ovf, logic [31:0] store,
                              logic [4:0] wreg, logic rw, logic m2r, logic mr, logic mw);
    out_t o;
    o = '{valid, res, valid && (res == 32'd0), ovf, store, wreg, rw, m2r, mr, mw};
    return o;
  endfunction

  // Reference ALU using 64-bit signed arithmetic for overflow detection.
  function automatic out_t model(logic [3:0] op, logic [31:0] a, logic [31:0] bfwd,
                                 logic [31:0] b, logic [4:0] wreg, logic [3:0] ctl);
    longint sa;
    longint sbv;
    longint r64;
    logic [31:0] r;
    logic ovf;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ovf = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1001: r = a ^ b;
      4'b0111: r = (sa < sbv) ? 32'd1 : 32'd0;
      4'b0110: begin r64 = sa - sbv; r = r64[31:0]; end
      default: begin r64 = sa + sbv; r = r64[31:0]; end
    endcase
    if (op == 4'b0110 || !(op inside {4'b0000, 4'b0001, 4'b1001, 4'b0111}))
      ovf = (r64 > 64'sd2147483647) || (r64 < -64'sd2147483648);
    return mk(1'b1, r, ovf, bfwd, wreg, ctl[3], ctl[2], ctl[1], ctl[0]);
  endfunction

  task automatic idle_inputs();
    rst = 0; inValid = 0; inStall = 0; inFlush = 0; inALUControl = 4'b0010; inALUSrc = 0;
    inReadData1 = 0; inReadData2 = 0; inImmediate = 0; inForwardA = 0; inForwardB = 0;
    inFwdMemData = 0; inFwdWbData = 0; inWriteReg = 0;
    inRegWrite = 0; inMemToReg = 0; inMemRead = 0; inMemWrite = 0;
  endtask

  task automatic drive_rr(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] wreg);
    idle_inputs();
    inValid = 1; inALUControl = op; inReadData1 = a; inReadData2 = b;
    inWriteReg = wreg; inRegWrite = 1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1; inValid = 1'($urandom); inStall = 1'($urandom); inFlush = 0;
      inALUControl = 4'($urandom); inALUSrc = 1'($urandom);
      inReadData1 = $urandom; inReadData2 = $urandom; inImmediate = $urandom;
      inForwardA = 2'($urandom); inForwardB = 2'($urandom);
      inFwdMemData = $urandom; inFwdWbData = $urandom; inWriteReg = 5'($urandom);
      inRegWrite = 1; inMemToReg = 1; inMemRead = 1; inMemWrite = 1;
      scoreboard.push_back('0);
      @(posedge clk); #1;
      got = sample_outputs(); exp = scoreboard.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reset[%0d] got=%h expected=%h", i, got, exp);
      end
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops[9]  = '{4'b0010, 4'b0110, 4'b0110, 4'b0111, 4'b0111, 4'b1001,
                             4'b0000, 4'b0001, 4'b1111};
    logic [31:0] as[9]   = '{32'd5, 32'h8000_0000, 32'd9, 32'hFFFF_FFFF, 32'd1, 32'h0000_F0F0,
                             32'h0000_F0F0, 32'h0000_F0F0, 32'h7FFF_FFFF};
    logic [31:0] bs[9]   = '{32'd7, 32'd1, 32'd9, 32'd1, 32'hFFFF_FFFF, 32'h0000_0FF0,
                             32'h0000_0FF0, 32'h0000_0FF0, 32'd1};
    logic [31:0] res[9]  = '{32'd12, 32'h7FFF_FFFF, 32'd0, 32'd1, 32'd0, 32'h0000_FF00,
                             32'h0000_00F0, 32'h0000_FFF0, 32'h8000_0000};
    logic        ovfs[9] = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive_rr(ops[i], as[i], bs[i], 5'(i + 3));
      scoreboard.push_back(mk(1, res[i], ovfs[i], bs[i], 5'(i + 3), 1, 0, 0, 0));
      @(posedge clk); #1;
      got = sample_outputs(); exp = scoreboard.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL alu_op[%0d] op=%b got=%h expected=%h", i, ops[i], got, exp);
      end
    end
  endtask

  task automatic test_forwarding();
    logic [1:0]  fa[4]    = '{2'b10, 2'b01, 2'b11, 2'b00};
    logic [1:0]  fb[4]    = '{2'b00, 2'b00, 2'b01, 2'b10};
    logic [31:0] imm[4]   = '{32'd1, 32'd1, 32'd1, 32'd4};
    logic [31:0] res[4]   = '{32'd101, 32'd201, 32'd2, 32'd5};
    logic [31:0] store[4] = '{32'd55, 32'd55, 32'd200, 32'd100};
    logic        sw[4]    = '{0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      inValid = 1; inALUControl = 4'b0010; inALUSrc = 1; inImmediate = imm[i];
      inReadData1 = 32'd1; inReadData2 = 32'd55; inFwdMemData = 32'd100; inFwdWbData = 32'd200;
      inForwardA = fa[i]; inForwardB = fb[i]; inWriteReg = 5'd9;
      inRegWrite = !sw[i]; inMemWrite = sw[i]; inMemRead = (i == 0); inMemToReg = (i == 0);
      scoreboard.push_back(mk(1, res[i], 0, store[i], 5'd9, !sw[i], i == 0, i == 0, sw[i]));
      @(posedge clk); #1;
      got = sample_outputs(); exp = scoreboard.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL forward[%0d] got=%h expected=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_stall_flush();
    // Steps: load ADD 5+7, stall, stall, stall+flush, reload, inValid=0 load, reload, stall+rst.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      case (i)
        0, 4, 6: begin
          drive_rr(4'b0010, 32'd5, 32'd7, 5'd17);
          exp = mk(1, 32'd12, 0, 32'd7, 5'd17, 1, 0, 0, 0);
        end
        1, 2: begin
          drive_rr(4'b0110, 32'd9 + 32'(i), 32'd9 + 32'(i), 5'd20);
          inStall = 1;
          exp = last_exp;
        end
        3: begin
          drive_rr(4'b0001, 32'd3, 32'd4, 5'd21);
          inStall = 1; inFlush = 1;
          exp = '0;
        end
        5: begin
          drive_rr(4'b0010, 32'd1, 32'd2, 5'd22);
          inValid = 0;
          exp = '0;
        end
        default: begin
          drive_rr(4'b0010, 32'd8, 32'd8, 5'd23);
          inStall = 1; rst = 1;
          exp = '0;
        end
      endcase
      last_exp = exp;
      scoreboard.push_back(exp);
      @(posedge clk); #1;
      got = sample_outputs(); exp = scoreboard.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL stall_flush[%0d] got=%h expected=%h", i, got, exp);
      end
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op_list[7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1001, 4'b1100};
    logic [31:0] edge_vals[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] a;
    logic [31:0] bf;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      idle_inputs();
      inValid = 1;
      inALUControl = op_list[$urandom_range(6)];
      inALUSrc = 1'($urandom);
      inReadData1 = ($urandom_range(3) == 0) ? edge_vals[$urandom_range(3)] : $urandom;
      inReadData2 = ($urandom_range(3) == 0) ? edge_vals[$urandom_range(3)] : $urandom;
      inImmediate = ($urandom_range(1) == 0) ? 32'($urandom_range(31)) : $urandom;
      inForwardA = 2'($urandom); inForwardB = 2'($urandom);
      inFwdMemData = $urandom; inFwdWbData = $urandom; inWriteReg = 5'($urandom);
      {inRegWrite, inMemToReg, inMemRead, inMemWrite} = 4'($urandom);
      a  = (inForwardA == 2'b01) ? inFwdWbData : (inForwardA == 2'b10) ? inFwdMemData : inReadData1;
      bf = (inForwardB == 2'b01) ? inFwdWbData : (inForwardB == 2'b10) ? inFwdMemData : inReadData2;
      scoreboard.push_back(model(inALUControl, a, bf, inALUSrc ? inImmediate : bf, inWriteReg,
                                 {inRegWrite, inMemToReg, inMemRead, inMemWrite}));
      @(posedge clk); #1;
      got = sample_outputs(); exp = scoreboard.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL back_to_back[%0d] op=%b got=%h expected=%h", i, inALUControl, got, exp);
      end
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle_inputs();
    test_reset();
    test_alu_ops();
    test_forwarding();
    test_stall_flush();
    test_back_to_back();
    checks++;
    if (scoreboard.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d expected=0", scoreboard.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
